// File: rtl/vadd_seq.sv
`default_nettype none
// ============================================================================
// Module   : vadd_seq
// Purpose  : Streams two FP16 vectors through the shared combinational FP16
//            adder, one element per cycle. Issues register-file reads,
//            registers the adder operands, registers the sums for write-back,
//            and reports completion and overflow status.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            start, sub, len     - operation request (A+B / A-B, element count)
//            rd_en, rd_idx       - register-file read strobe / element index
//            a_data, b_data      - operands, valid one cycle after rd_en
//            add_a, add_b        - registered adder operands
//            add_sum, add_ovf    - combinational adder result / overflow flag
//            wr_en, wr_idx,
//            wr_data             - result write-back
//            busy, done          - operation in progress / completion pulse
//            ovf_sticky,
//            ovf_count           - overflow status of the last operation
// Revision : 1.0 - initial release
// ============================================================================
module vadd_seq #(
  parameter int NELEM = 32,
  parameter int IDXW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            sub,
  input  logic [IDXW:0]   len,
  output logic            rd_en,
  output logic [IDXW-1:0] rd_idx,
  input  logic [15:0]     a_data,
  input  logic [15:0]     b_data,
  output logic [15:0]     add_a,
  output logic [15:0]     add_b,
  input  logic [15:0]     add_sum,
  input  logic            add_ovf,
  output logic            wr_en,
  output logic [IDXW-1:0] wr_idx,
  output logic [15:0]     wr_data,
  output logic            busy,
  output logic            done,
  output logic            ovf_sticky,
  output logic [IDXW:0]   ovf_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [IDXW:0] c_nelem = (IDXW+1)'(NELEM);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_sub;
  logic [IDXW:0]     r_len;
  logic              r_rd_en;
  logic [IDXW-1:0]   r_rd_idx;
  // Pipeline: r_dv marks operands arriving from the register file this
  // cycle, r_v1 marks valid adder operands, r_wr_en is the write stage.
  logic              r_dv;
  logic [IDXW-1:0]   r_idx_d;
  logic              r_v1;
  logic [IDXW-1:0]   r_idx1;
  logic [15:0]       r_add_a;
  logic [15:0]       r_add_b;
  logic              r_wr_en;
  logic [IDXW-1:0]   r_wr_idx;
  logic [15:0]       r_wr_data;
  logic              r_busy;
  logic              r_done;
  logic              r_ovf_sticky;
  logic [IDXW:0]     r_ovf_count;

  logic              w_can_start;
  logic              w_accept;
  logic [IDXW:0]     w_len_clamp;
  logic              w_last;

  // A new operation may be accepted in IDLE and also in the DONE cycle,
  // which allows back-to-back operations without a dead cycle.
  assign w_can_start = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_accept    = start && w_can_start;
  assign w_len_clamp = (len > c_nelem) ? c_nelem : len;
  // Only evaluated in ISSUE, where r_len is at least 1.
  assign w_last      = ({1'b0, r_rd_idx} == (r_len - 1'b1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          // A zero-length operation passes through DRAIN with an empty
          // pipeline, giving one busy cycle before the done pulse.
          w_state_nxt = (w_len_clamp != '0) ? S_ISSUE : S_DRAIN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (w_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!r_dv && !r_v1) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_sub        <= 1'b0;
      r_len        <= '0;
      r_rd_en      <= 1'b0;
      r_rd_idx     <= '0;
      r_dv         <= 1'b0;
      r_idx_d      <= '0;
      r_v1         <= 1'b0;
      r_idx1       <= '0;
      r_add_a      <= '0;
      r_add_b      <= '0;
      r_wr_en      <= 1'b0;
      r_wr_idx     <= '0;
      r_wr_data    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_ovf_sticky <= 1'b0;
      r_ovf_count  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_ISSUE) || (w_state_nxt == S_DRAIN);
      r_done  <= (w_state_nxt == S_DONE);

      // Read issue: index counter restarts on accept, advances while issuing.
      r_rd_en <= (w_state_nxt == S_ISSUE);
      if (w_accept) begin
        r_rd_idx <= '0;
      end else if ((r_state == S_ISSUE) && !w_last) begin
        r_rd_idx <= r_rd_idx + 1'b1;
      end

      if (w_accept) begin
        r_sub <= sub;
        r_len <= w_len_clamp;
      end

      // Register-file read latency stage.
      r_dv    <= r_rd_en;
      r_idx_d <= r_rd_idx;

      // S1: adder operands; subtraction flips the sign of B.
      r_v1 <= r_dv;
      if (r_dv) begin
        r_add_a <= a_data;
        r_add_b <= {b_data[15] ^ r_sub, b_data[14:0]};
        r_idx1  <= r_idx_d;
      end

      // S2: result write-back.
      r_wr_en <= r_v1;
      if (r_v1) begin
        r_wr_data <= add_sum;
        r_wr_idx  <= r_idx1;
      end

      // Overflow status; an accepted start only happens with an empty
      // pipeline, so clearing never competes with an update.
      if (w_accept) begin
        r_ovf_sticky <= 1'b0;
        r_ovf_count  <= '0;
      end else if (r_v1 && add_ovf) begin
        r_ovf_sticky <= 1'b1;
        r_ovf_count  <= r_ovf_count + 1'b1;
      end
    end
  end

  assign rd_en      = r_rd_en;
  assign rd_idx     = r_rd_idx;
  assign add_a      = r_add_a;
  assign add_b      = r_add_b;
  assign wr_en      = r_wr_en;
  assign wr_idx     = r_wr_idx;
  assign wr_data    = r_wr_data;
  assign busy       = r_busy;
  assign done       = r_done;
  assign ovf_sticky = r_ovf_sticky;
  assign ovf_count  = r_ovf_count;

endmodule
`default_nettype wire

// File: tb/tb_vadd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_vadd_seq
// Purpose  : Directed self-checking bench for vadd_seq. Provides a 1-cycle
//            synchronous register-file model and a table-driven stand-in for
//            the FP16 adder, logs reads/writes relative to the start cycle,
//            and checks them against hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vadd_seq;
  localparam int NELEM = 32;
  localparam int IDXW  = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            sub = 1'b0;
  logic [IDXW:0]   len = '0;
  logic            rd_en;
  logic [IDXW-1:0] rd_idx;
  logic [15:0]     a_data = '0;
  logic [15:0]     b_data = '0;
  logic [15:0]     add_a, add_b;
  logic [15:0]     add_sum;
  logic            add_ovf;
  logic            wr_en;
  logic [IDXW-1:0] wr_idx;
  logic [15:0]     wr_data;
  logic            busy, done, ovf_sticky;
  logic [IDXW:0]   ovf_count;

  vadd_seq #(.NELEM(NELEM), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .len(len),
    .rd_en(rd_en), .rd_idx(rd_idx), .a_data(a_data), .b_data(b_data),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_ovf(add_ovf),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .busy(busy), .done(done), .ovf_sticky(ovf_sticky), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file model: 1-cycle synchronous read.
  logic [15:0] mem_a [NELEM];
  logic [15:0] mem_b [NELEM];
  always @(posedge clk) begin
    if (rd_en) begin
      a_data <= mem_a[rd_idx];
      b_data <= mem_b[rd_idx];
    end
  end

  // Adder stand-in: known FP16 pairs from the directed vectors, otherwise a
  // plain integer sum (used only for the long-vector index/ordering test).
  always_comb begin
    add_sum = add_a + add_b;
    add_ovf = 1'b0;
    case ({add_a, add_b})
      {16'h3C00, 16'h3C00}: add_sum = 16'h4000;
      {16'h4000, 16'h3C00}: add_sum = 16'h4200;
      {16'h3C00, 16'hBC00}: add_sum = 16'h0000;
      {16'h7BFF, 16'h7BFF}: begin add_sum = 16'h7C00; add_ovf = 1'b1; end
      default: ;
    endcase
  end

  typedef struct { int cyc; logic [4:0] idx; logic [15:0] data; } ev_t;
  ev_t wr_q[$];
  ev_t rd_q[$];
  int  c0 = 0;
  int  n_done = 0;
  int  first_busy = -1;
  int  last_busy = -1;
  int  done_cyc = -1;
  logic       o1_sticky;
  logic [5:0] o1_count;
  int  total = 0;
  int  bad = 0;

  // Event logger, sampled on the falling edge; cycle numbers are relative
  // to the cycle in which start was sampled (cycle 0).
  always @(negedge clk) begin
    int rel;
    rel = cyc - c0;
    if (rel > 0) begin
      if (rd_en) rd_q.push_back('{rel, rd_idx, 16'h0});
      if (wr_en) wr_q.push_back('{rel, wr_idx, wr_data});
      if (done)  n_done++;
      if (busy) begin
        if (first_busy < 0) first_busy = rel;
        last_busy = rel;
      end
    end
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: drives start for one cycle, returns in cycle 1.
  task automatic start_op(input logic s, input int n);
    c0 = cyc;
    wr_q.delete();
    rd_q.delete();
    n_done = 0;
    first_busy = -1;
    last_busy = -1;
    done_cyc = -1;
    start = 1'b1;
    sub = s;
    len = 6'(n);
    @(negedge clk);
    start = 1'b0;
    sub = 1'b0;
    o1_sticky = ovf_sticky;
    o1_count = ovf_count;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) begin
        done_cyc = cyc - c0;
        break;
      end
    end
    chk("done_seen", done, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < NELEM; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end

    // Reset state.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {rd_en, rd_idx, add_a, add_b, wr_en, wr_idx, wr_data,
                          busy, done, ovf_sticky, ovf_count}, 80'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic add, len=2.
    mem_a[0] = 16'h3C00; mem_a[1] = 16'h4000;
    mem_b[0] = 16'h3C00; mem_b[1] = 16'h3C00;
    start_op(1'b0, 2);
    wait_done();
    chk("t1_nwr", wr_q.size(), 2);
    chk("t1_wr0", {wr_q[0].idx, wr_q[0].data, 16'(wr_q[0].cyc)}, {5'd0, 16'h4000, 16'd4});
    chk("t1_wr1", {wr_q[1].idx, wr_q[1].data, 16'(wr_q[1].cyc)}, {5'd1, 16'h4200, 16'd5});
    chk("t1_rd", {16'(rd_q.size()), 16'(rd_q[0].cyc), rd_q[0].idx, 16'(rd_q[1].cyc), rd_q[1].idx},
                 {16'd2, 16'd1, 5'd0, 16'd2, 5'd1});
    chk("t1_done_cyc", done_cyc, 6);
    chk("t1_busy", {16'(first_busy), 16'(last_busy), busy}, {16'd1, 16'd5, 1'b0});
    chk("t1_ovf", {ovf_sticky, ovf_count}, 7'd0);

    // Subtract, len=1.
    start_op(1'b1, 1);
    wait_done();
    chk("t2_operands", {add_a, add_b}, {16'h3C00, 16'hBC00});
    chk("t2_wr0", {16'(wr_q.size()), wr_q[0].idx, wr_q[0].data, 16'(wr_q[0].cyc)},
                  {16'd1, 5'd0, 16'h0000, 16'd4});
    chk("t2_done_cyc", done_cyc, 5);

    // Overflow on element 1 of 3.
    mem_a[1] = 16'h7BFF; mem_b[1] = 16'h7BFF;
    mem_a[2] = 16'h4000; mem_b[2] = 16'h3C00;
    start_op(1'b0, 3);
    wait_done();
    chk("t3_nwr", wr_q.size(), 3);
    chk("t3_wr1", {wr_q[1].idx, wr_q[1].data, 16'(wr_q[1].cyc)}, {5'd1, 16'h7C00, 16'd5});
    chk("t3_ovf", {ovf_sticky, ovf_count}, {1'b1, 6'd1});
    chk("t3_done_cyc", done_cyc, 7);

    // len=0: no traffic; the accepted start clears the overflow status.
    start_op(1'b0, 0);
    chk("t4_ovf_cleared", {o1_sticky, o1_count}, 7'd0);
    wait_done();
    chk("t4_done_cyc", done_cyc, 2);
    chk("t4_no_traffic", {16'(rd_q.size()), 16'(wr_q.size())}, 32'd0);
    chk("t4_busy", {16'(first_busy), 16'(last_busy)}, {16'd1, 16'd1});

    // Oversized len clamps to NELEM.
    for (int i = 0; i < NELEM; i++) begin
      mem_a[i] = 16'(i);
      mem_b[i] = 16'h0100 + 16'(i);
    end
    start_op(1'b0, NELEM + 5);
    wait_done();
    chk("t5_nwr", wr_q.size(), 32);
    begin
      int nbad;
      nbad = 0;
      for (int i = 0; i < wr_q.size(); i++) begin
        if (wr_q[i].idx !== 5'(i) || wr_q[i].data !== (16'h0100 + 16'(2 * i)) ||
            wr_q[i].cyc != 4 + i)
          nbad++;
      end
      chk("t5_wr_seq", nbad, 0);
    end
    chk("t5_last_idx", wr_q[31].idx, 5'd31);
    chk("t5_done_cyc", done_cyc, 36);

    // Start while busy is ignored.
    mem_a[0] = 16'h3C00; mem_a[1] = 16'h4000; mem_a[2] = 16'h3C00; mem_a[3] = 16'h4000;
    mem_b[0] = 16'h3C00; mem_b[1] = 16'h3C00; mem_b[2] = 16'h3C00; mem_b[3] = 16'h3C00;
    start_op(1'b0, 4);
    @(negedge clk);
    start = 1'b1; sub = 1'b1; len = 6'd2;
    @(negedge clk);
    start = 1'b0; sub = 1'b0;
    wait_done();
    chk("t6_nrd", rd_q.size(), 4);
    chk("t6_rd3", {rd_q[3].idx, 16'(rd_q[3].cyc)}, {5'd3, 16'd4});
    chk("t6_nwr", wr_q.size(), 4);
    chk("t6_wr3", {wr_q[3].idx, wr_q[3].data, 16'(wr_q[3].cyc)}, {5'd3, 16'h4200, 16'd7});
    chk("t6_add_b_sign", add_b, 16'h3C00);
    chk("t6_done_cyc", done_cyc, 8);

    // Back-to-back: start applied in the done cycle.
    chk("t7_in_done", {done, busy}, 2'b10);
    start_op(1'b0, 1);
    wait_done();
    chk("t7_rd0", {16'(rd_q.size()), rd_q[0].idx, 16'(rd_q[0].cyc)}, {16'd1, 5'd0, 16'd1});
    chk("t7_wr0", {wr_q[0].data, 16'(wr_q[0].cyc)}, {16'h4000, 16'd4});
    chk("t7_done_cyc", done_cyc, 5);

    // Reset in cycle 3 of a len=8 operation.
    for (int i = 0; i < 8; i++) begin
      mem_a[i] = 16'h3C00;
      mem_b[i] = 16'h3C00;
    end
    start_op(1'b0, 8);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t8_reset_outputs", {rd_en, rd_idx, add_a, add_b, wr_en, wr_idx, wr_data,
                             busy, done, ovf_sticky, ovf_count}, 80'd0);
    rst = 1'b0;
    wr_q.delete();
    rd_q.delete();
    n_done = 0;
    repeat (12) @(negedge clk);
    chk("t8_quiet", {16'(rd_q.size()), 16'(wr_q.size()), 16'(n_done)}, 48'd0);

    // Normal operation after reset.
    mem_a[0] = 16'h3C00; mem_a[1] = 16'h4000;
    mem_b[0] = 16'h3C00; mem_b[1] = 16'h3C00;
    start_op(1'b0, 2);
    wait_done();
    chk("t9_wr", {16'(wr_q.size()), wr_q[1].idx, wr_q[1].data, 16'(wr_q[1].cyc)},
                 {16'd2, 5'd1, 16'h4200, 16'd5});
    chk("t9_done_cyc", done_cyc, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
